// File: rtl/dac_spi_writer_pkg.sv
// Shared definitions for the DAC SPI writer: default widths, the DAC
// command prefix, FSM state encoding and the frame-length helper.
package dac_spi_writer_pkg;

  localparam int         DATA_WIDTH_DEF = 12;
  localparam int         CMD_BITS_DEF   = 4;
  localparam logic [3:0] CMD_WORD_DEF   = 4'b0011;  // write and update
  localparam int         CLK_DIV_DEF    = 4;
  localparam int         CS_HIGH_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int frame_bits(input int data_width, input int cmd_bits);
    return data_width + cmd_bits;
  endfunction

endpackage

// File: rtl/dac_spi_writer_spi_tick_gen.sv
// SCLK half-period timer. Down-counts CLK_DIV cycles while enabled and
// raises tick for one cycle at each terminal count; reloads when disabled
// so every frame starts with a full half-period.
// Ports: clk, rst (sync, active high), en (count enable), tick (half-period end).
module spi_tick_gen
  import dac_spi_writer_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises offset-binary samples into CS-framed, MSB-first SPI writes
// ({CMD_WORD, sample}) for the actuator-channel DAC. One word is taken per
// valid/ready handshake; nothing is buffered beyond the word being shifted.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   data_in/valid/ready upstream handshake (accept = valid & ready)
//   dac_cs_n/sclk/sdi   SPI to DAC (sclk idle low, DAC samples on rise)
//   busy                high from accept until data_ready returns
//   frame_done          one-cycle pulse when data_ready returns high
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | data_ready high, waiting for a word
// ST_SETUP | cs_n low, sclk low for one half-period before the first rise
// ST_SHIFT | clocking bits out; sdi advances on each sclk fall
// ST_HOLD  | cs_n high for CS_HIGH cycles before the next frame may start
module dac_spi_writer
  import dac_spi_writer_pkg::*;
#(
  parameter int                  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                  CMD_BITS   = CMD_BITS_DEF,
  parameter logic [CMD_BITS-1:0] CMD_WORD   = CMD_BITS'(CMD_WORD_DEF),
  parameter int                  CLK_DIV    = CLK_DIV_DEF,
  parameter int                  CS_HIGH    = CS_HIGH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  dac_cs_n,
  output logic                  dac_sclk,
  output logic                  dac_sdi,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAME_BITS = frame_bits(DATA_WIDTH, CMD_BITS);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int HOLD_W     = $clog2(CS_HIGH + 1);

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic                    tick;
  logic                    accept;

  assign accept = data_valid && data_ready;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_ready <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_sdi    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg      <= {CMD_WORD, data_in};
            dac_sdi    <= CMD_WORD[CMD_BITS-1];
            dac_cs_n   <= 1'b0;
            dac_sclk   <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b1;
            bit_cnt    <= BIT_W'(FRAME_BITS - 1);
            state      <= ST_SETUP;
          end else begin
            data_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            dac_sclk <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // bit_cnt is the index of the bit currently on sdi; it steps on
          // each rise so bit 0's low phase can be told apart from bit 1's.
          if (tick) begin
            if (dac_sclk) begin
              dac_sclk <= 1'b0;
              if (bit_cnt != '0) begin
                shreg   <= shreg << 1;
                dac_sdi <= shreg[FRAME_BITS-2];
              end
            end else if (bit_cnt == '0) begin
              dac_cs_n <= 1'b1;
              hold_cnt <= HOLD_W'(CS_HIGH - 1);
              state    <= ST_HOLD;
            end else begin
              dac_sclk <= 1'b1;
              bit_cnt  <= bit_cnt - 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            data_ready <= 1'b1;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: a default build (CLK_DIV=4, CS_HIGH=2) and a
// fast build (CLK_DIV=1, CS_HIGH=1) share clock and reset. A negedge monitor
// pushes {4'b0011, data_in} on every predicted accept and reassembles frames
// from sdi on sclk rises, comparing against the queue and frame timing.
module tb_dac_spi_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din_a = '0, din_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, cs_n_a, sclk_a, sdi_a, busy_a, done_a;
  logic        ready_b, cs_n_b, sclk_b, sdi_b, busy_b, done_b;

  wire [1:0]  ready = {ready_b, ready_a};
  wire [1:0]  cs_n  = {cs_n_b, cs_n_a};
  wire [1:0]  sclk  = {sclk_b, sclk_a};
  wire [1:0]  sdi   = {sdi_b, sdi_a};
  wire [1:0]  busy  = {busy_b, busy_a};
  wire [1:0]  done  = {done_b, done_a};
  wire [1:0]  valid = {valid_b, valid_a};
  wire [11:0] din [2];
  assign din[0] = din_a;
  assign din[1] = din_b;

  always #5 clk = ~clk;

  dac_spi_writer u_dut_a (
    .clk(clk), .rst(rst), .data_in(din_a), .data_valid(valid_a), .data_ready(ready_a),
    .dac_cs_n(cs_n_a), .dac_sclk(sclk_a), .dac_sdi(sdi_a), .busy(busy_a), .frame_done(done_a)
  );

  dac_spi_writer #(.CLK_DIV(1), .CS_HIGH(1)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(din_b), .data_valid(valid_b), .data_ready(ready_b),
    .dac_cs_n(cs_n_b), .dac_sclk(sclk_b), .dac_sdi(sdi_b), .busy(busy_b), .frame_done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard state, index 0 = default build, 1 = fast build
  int          cyc = 0;
  logic [15:0] sbq_a[$];
  logic [15:0] sbq_b[$];
  int          exp_cs  [2] = '{132, 33};
  int          exp_rdy [2] = '{134, 34};
  int          cs_low_cnt [2] = '{0, 0};
  int          rdy_low_cnt[2] = '{0, 0};
  int          acc_cyc    [2] = '{0, 0};
  int          rise_cyc   [2] = '{0, 0};
  int          nbits      [2] = '{0, 0};
  int          frames     [2] = '{0, 0};
  logic [15:0] shv        [2] = '{16'h0, 16'h0};
  logic        in_frame   [2] = '{1'b0, 1'b0};
  logic        pending    [2] = '{1'b0, 1'b0};
  logic        prev_cs    [2] = '{1'b1, 1'b1};
  logic        prev_sclk  [2] = '{1'b0, 1'b0};
  logic        cur_bit    [2] = '{1'b0, 1'b0};
  logic        gap_chk = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [15:0] expf;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_frame[i] = 1'b0;
        pending[i]  = 1'b0;
        nbits[i]    = 0;
        if (i == 0) sbq_a.delete(); else sbq_b.delete();
        prev_cs[i]   = 1'b1;
        prev_sclk[i] = 1'b0;
      end else begin
        if (prev_cs[i] && !cs_n[i]) begin
          check_eq("cs_fall_has_word", pending[i], 1'b1);
          if (i == 0 && gap_chk) check_eq("cs_high_gap", cyc - rise_cyc[i], 3);
          in_frame[i]   = 1'b1;
          cs_low_cnt[i] = 0;
          nbits[i]      = 0;
          shv[i]        = '0;
        end
        if (in_frame[i] && !cs_n[i]) begin
          cs_low_cnt[i]++;
          if (sclk[i] && !prev_sclk[i]) begin
            shv[i]     = {shv[i][14:0], sdi[i]};
            cur_bit[i] = sdi[i];
            nbits[i]++;
          end else if (sclk[i] && prev_sclk[i]) begin
            check_eq("sdi_stable_high", sdi[i], cur_bit[i]);
          end
        end
        if (in_frame[i] && cs_n[i] && !prev_cs[i]) begin
          in_frame[i] = 1'b0;
          rise_cyc[i] = cyc;
          frames[i]++;
          check_eq("cs_low_len", cs_low_cnt[i], exp_cs[i]);
          check_eq("sclk_rises", nbits[i], 16);
          if (i == 0 && sbq_a.size() > 0) expf = sbq_a.pop_front();
          else if (i == 1 && sbq_b.size() > 0) expf = sbq_b.pop_front();
          else expf = 16'hxxxx;
          check_eq("frame_data", shv[i], expf);
        end
        if (pending[i] && !ready[i]) rdy_low_cnt[i]++;
        if (done[i]) begin
          check_eq("done_expected", pending[i], 1'b1);
          check_eq("done_latency", cyc - acc_cyc[i], exp_rdy[i]);
          check_eq("ready_low_len", rdy_low_cnt[i], exp_rdy[i]);
          check_eq("ready_with_done", ready[i], 1'b1);
          check_eq("busy_clear_at_done", busy[i], 1'b0);
          pending[i] = 1'b0;
        end
        if (valid[i] && ready[i]) begin
          if (i == 0) sbq_a.push_back({4'b0011, din[i]});
          else        sbq_b.push_back({4'b0011, din[i]});
          acc_cyc[i]     = cyc + 1;
          pending[i]     = 1'b1;
          rdy_low_cnt[i] = 0;
        end
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
    end
  end

  task automatic set_in(input int i, input logic [11:0] w, input logic v);
    if (i == 0) begin din_a = w; valid_a = v; end
    else        begin din_b = w; valid_b = v; end
  endtask

  task automatic send(input int i, input logic [11:0] w);
    int n;
    @(posedge clk); #1;
    set_in(i, w, 1'b1);
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ready[i]) break;
    end
    check_eq("send_ready", ready[i], 1'b1);
    @(posedge clk); #1;
    set_in(i, w, 1'b0);
    @(negedge clk);
    check_eq("acc_busy", busy[i], 1'b1);
    check_eq("acc_cs_low", cs_n[i], 1'b0);
    check_eq("acc_ready_low", ready[i], 1'b0);
  endtask

  task automatic wait_idle(input int i);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!pending[i] && ready[i]) break;
    end
    check_eq("idle_reached", (n < 400), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [11:0] w3 [3] = '{12'h1F0, 12'h0E7, 12'hC3A};
  int          rises;
  logic        ps;

  initial begin
    // 1: reset values, then a single word
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", ready, 2'b00);
    check_eq("rst_cs_n", cs_n, 2'b11);
    check_eq("rst_sclk", sclk, 2'b00);
    check_eq("rst_sdi", sdi, 2'b00);
    check_eq("rst_busy", busy, 2'b00);
    check_eq("rst_done", done, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", ready, 2'b11);
    send(0, 12'hA5C);
    wait_idle(0);

    // 2: boundary data
    send(0, 12'h000);
    wait_idle(0);
    send(0, 12'hFFF);
    wait_idle(0);

    // 3: valid held high for three words
    @(posedge clk); #1;
    din_a = w3[0]; valid_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (ready[0]) break;
      end
      check_eq("b2b_ready", ready[0], 1'b1);
      @(posedge clk); #1;
      if (k < 2) din_a = w3[k+1];
      else valid_a = 1'b0;
      if (k == 0) begin
        @(posedge clk); #1;
        gap_chk = 1'b1;
      end
    end
    wait_idle(0);
    gap_chk = 1'b0;

    // 4: valid pulsed mid-frame is ignored, data_in change does not leak in
    send(0, 12'h6B2);
    repeat (40) @(posedge clk);
    #1;
    din_a = 12'h123; valid_a = 1'b1;
    @(negedge clk);
    check_eq("ignored_ready", ready[0], 1'b0);
    @(posedge clk); #1;
    valid_a = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    check_eq("no_extra_frame_q", sbq_a.size(), 0);
    check_eq("no_extra_frame_cs", cs_n[0], 1'b1);

    // 5: reset at the 7th sclk rise abandons the frame
    send(0, 12'h7E1);
    rises = 0;
    ps = 1'b0;
    for (int n = 0; n < 200 && rises < 7; n++) begin
      @(negedge clk);
      if (sclk[0] && !ps) rises++;
      ps = sclk[0];
    end
    check_eq("rst_rise7", rises, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_cs_n", cs_n[0], 1'b1);
    check_eq("mid_rst_sclk", sclk[0], 1'b0);
    check_eq("mid_rst_sdi", sdi[0], 1'b0);
    check_eq("mid_rst_done", done[0], 1'b0);
    check_eq("mid_rst_busy", busy[0], 1'b0);
    check_eq("mid_rst_ready", ready[0], 1'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    send(0, 12'h2C4);
    wait_idle(0);

    // 6: fast build
    send(1, 12'h800);
    wait_idle(1);

    repeat (20) @(negedge clk);
    check_eq("frames_a", frames[0], 8);
    check_eq("frames_b", frames[1], 1);
    check_eq("sb_a_empty", sbq_a.size(), 0);
    check_eq("sb_b_empty", sbq_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
